// File: rtl/morph_3x3_filter.sv
// morph_3x3_filter
// Binary erosion/dilation over a streamed 3x3 window. Each window pixel is
// thresholded to one bit, the nine bits are AND-reduced (erosion) or
// OR-reduced (dilation), and the result is emitted as 8'hFF / 8'h00.
// Window columns 0 and 1 produce BORDER_VAL instead. The reduction mode is
// latched on the first window of a frame and held until the next frame.
// Fixed two-cycle latency, no backpressure; output gaps follow input gaps.

module morph_3x3_filter #(
  parameter logic [15:0] CNT_COL_MAX = 16'd1023,
  parameter logic [15:0] CNT_ROW_MAX = 16'd765,
  parameter logic [7:0]  THRESH      = 8'd128,
  parameter logic [7:0]  BORDER_VAL  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_sel,
  input  logic       data_en,
  input  logic [7:0] p11,
  input  logic [7:0] p12,
  input  logic [7:0] p13,
  input  logic [7:0] p21,
  input  logic [7:0] p22,
  input  logic [7:0] p23,
  input  logic [7:0] p31,
  input  logic [7:0] p32,
  input  logic [7:0] p33,
  output logic       dout_en,
  output logic [7:0] dout,
  output logic       frame_done
);

  // Window position counters and the per-frame mode latch
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        mode_q, mode_d;

  // Stage 1 registers: thresholded bits plus side-band flags
  logic [8:0]  bits1_q, bits1_d;
  logic        valid1_q, valid1_d;
  logic        border1_q, border1_d;
  logic        last1_q, last1_d;
  logic        mode1_q, mode1_d;

  // Stage 2 registers: the visible outputs
  logic        dout_en_q, dout_en_d;
  logic [7:0]  dout_q, dout_d;
  logic        frame_done_q, frame_done_d;

  logic        first_win;
  logic        col_wrap;
  logic        eff_mode;
  logic        reduce_bit;

  // Track window column/row and latch the mode on the first window of a frame
  always_comb begin
    first_win = (col_q == 16'd0) && (row_q == 16'd0);
    col_wrap  = (col_q == CNT_COL_MAX);
    eff_mode  = first_win ? mode_sel : mode_q;
    col_d     = col_q;
    row_d     = row_q;
    mode_d    = mode_q;
    if (data_en) begin
      if (first_win) begin
        mode_d = mode_sel;
      end
      if (col_wrap) begin
        col_d = 16'd0;
        row_d = (row_q == CNT_ROW_MAX) ? 16'd0 : row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  // Stage 1: binarize every window pixel and capture the window's flags
  always_comb begin
    bits1_d   = {p33 >= THRESH, p32 >= THRESH, p31 >= THRESH,
                 p23 >= THRESH, p22 >= THRESH, p21 >= THRESH,
                 p13 >= THRESH, p12 >= THRESH, p11 >= THRESH};
    valid1_d  = data_en;
    border1_d = (col_q < 16'd2);
    last1_d   = col_wrap && (row_q == CNT_ROW_MAX);
    mode1_d   = eff_mode;
  end

  // Stage 2: reduce the nine bits and form the output pixel, holding dout when idle
  always_comb begin
    reduce_bit   = mode1_q ? (|bits1_q) : (&bits1_q);
    dout_en_d    = valid1_q;
    frame_done_d = valid1_q & last1_q;
    dout_d       = dout_q;
    if (valid1_q) begin
      if (border1_q) begin
        dout_d = BORDER_VAL;
      end else begin
        dout_d = reduce_bit ? 8'hFF : 8'h00;
      end
    end
  end

  // All state registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= 16'd0;
      row_q        <= 16'd0;
      mode_q       <= 1'b0;
      bits1_q      <= 9'd0;
      valid1_q     <= 1'b0;
      border1_q    <= 1'b0;
      last1_q      <= 1'b0;
      mode1_q      <= 1'b0;
      dout_en_q    <= 1'b0;
      dout_q       <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      bits1_q      <= bits1_d;
      valid1_q     <= valid1_d;
      border1_q    <= border1_d;
      last1_q      <= last1_d;
      mode1_q      <= mode1_d;
      dout_en_q    <= dout_en_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout_en    = dout_en_q;
  assign dout       = dout_q;
  assign frame_done = frame_done_q;

endmodule
